alloc_frontend: RTL and testbench

Front-end stage directly upstream of the 4-entry slot allocator (lowest-free alloc, highest-valid dealloc).
- Converts valid/ready request and release streams into the allocator's single-cycle alloc/dealloc strobes.
- Holds a payload per slot, indexed by the allocator's positions, and returns the payload of the slot being freed.
- Provides a flush state machine, occupancy status and a sticky consistency-error flag.

---
 rtl/alloc_pkg.sv | 45 ++++
 rtl/alloc_payload_ram.sv | 23 ++
 rtl/alloc_frontend.sv | 103 ++++++++++
 tb/tb_alloc_frontend.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alloc_pkg.sv
// Shared types and helpers for the 4-entry slot allocator and its front end.
package alloc_pkg;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IDX_W = 2;

  typedef logic [DEPTH-1:0] slot_vec_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;

  typedef enum logic {
    FE_IDLE,
    FE_FLUSH
  } fe_state_t;

  // Index of the lowest clear bit; 0 when every slot is taken.
  function automatic idx_t lowest_free(slot_vec_t v);
    idx_t r;
    r = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!v[i]) r = idx_t'(i);
    end
    return r;
  endfunction

  // Index of the highest set bit; 0 when no slot is valid.
  function automatic idx_t highest_valid(slot_vec_t v);
    idx_t r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (v[i]) r = idx_t'(i);
    end
    return r;
  endfunction

  function automatic cnt_t popcount(slot_vec_t v);
    cnt_t r;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      r = r + {{IDX_W{1'b0}}, v[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/alloc_payload_ram.sv
// Per-slot payload storage: one synchronous write port, one asynchronous read port.
module alloc_payload_ram
  import alloc_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  idx_t              waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  idx_t              raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alloc_frontend.sv
// Valid/ready front end for the slot allocator: strobe generation, payload store,
// flush sequencing, occupancy status and a sticky shadow-consistency error.
module alloc_frontend
  import alloc_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_data,
  output logic              req_ready,
  output logic [1:0]        alloc_idx,
  input  logic              rel_valid,
  output logic              rel_ready,
  output logic [DATA_W-1:0] rel_data,
  output logic [1:0]        rel_idx,
  input  logic              flush,
  output logic              flush_busy,
  input  logic [DEPTH-1:0]  q_valid,
  output logic              alloc,
  output logic              dealloc,
  output logic [2:0]        count,
  output logic              full,
  output logic              empty,
  output logic              err
);

  if (DEPTH != alloc_pkg::DEPTH) begin : g_depth_check
    $error("alloc_frontend only supports DEPTH = 4");
  end

  fe_state_t state_q;
  slot_vec_t shadow_q, shadow_d;
  logic      err_q, err_d;
  logic      in_idle;

  assign alloc_idx = lowest_free(q_valid);
  assign rel_idx   = highest_valid(q_valid);
  assign count     = popcount(q_valid);
  assign full      = &q_valid;
  assign empty     = ~|q_valid;

  assign in_idle    = (state_q == FE_IDLE);
  assign req_ready  = !rst && in_idle && !full;
  assign rel_ready  = !rst && in_idle && !empty;
  assign flush_busy = !rst && !in_idle;
  assign alloc      = req_valid && req_ready;

  // Flush drains one slot per cycle until the allocator reports empty.
  always_comb begin
    dealloc = 1'b0;
    if (!rst) begin
      if (in_idle) dealloc = rel_valid && rel_ready;
      else         dealloc = !empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FE_IDLE;
    end else begin
      case (state_q)
        FE_IDLE:  if (flush && !empty) state_q <= FE_FLUSH;
        FE_FLUSH: if (empty) state_q <= FE_IDLE;
        default:  state_q <= FE_IDLE;
      endcase
    end
  end

  // Built from the live q_valid, so a mismatch implicitly resynchronises the shadow.
  always_comb begin
    shadow_d = q_valid;
    if (alloc)   shadow_d[alloc_idx] = 1'b1;
    if (dealloc) shadow_d[rel_idx]   = 1'b0;
    err_d = err_q || (shadow_q != q_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      err_q    <= err_d;
    end
  end

  assign err = err_q;

  alloc_payload_ram #(
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (alloc),
    .waddr_i (alloc_idx),
    .wdata_i (req_data),
    .raddr_i (rel_idx),
    .rdata_o (rel_data)
  );

endmodule

// File: tb/tb_alloc_frontend.sv
// Directed bench for alloc_frontend with a behavioural allocator/front-end model.
module tb_alloc_frontend;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_data;
  logic       req_ready;
  logic [1:0] alloc_idx;
  logic       rel_valid;
  logic       rel_ready;
  logic [7:0] rel_data;
  logic [1:0] rel_idx;
  logic       flush;
  logic       flush_busy;
  logic [3:0] q_valid;
  logic       alloc;
  logic       dealloc;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic       err;

  always #5 clk = ~clk;

  alloc_frontend #(
    .DEPTH  (4),
    .DATA_W (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .alloc_idx  (alloc_idx),
    .rel_valid  (rel_valid),
    .rel_ready  (rel_ready),
    .rel_data   (rel_data),
    .rel_idx    (rel_idx),
    .flush      (flush),
    .flush_busy (flush_busy),
    .q_valid    (q_valid),
    .alloc      (alloc),
    .dealloc    (dealloc),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .err        (err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state
  bit         m_flush = 1'b0;
  bit         m_err = 1'b0;
  logic [3:0] m_pred = 4'b0000;
  logic [7:0] m_pay [4];
  bit         m_known [4];
  bit         force_en;
  logic [3:0] force_val;

  // Expected strobes/indices for the current cycle, captured by the compare process
  bit e_alloc = 1'b0;
  bit e_dealloc = 1'b0;
  int e_lf = 0;
  int e_hv = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_zero(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  function automatic int highest_one(input logic [3:0] v);
    for (int i = 3; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [3:0] alloc_next(input logic [3:0] v, input bit a, input bit d,
                                            input int lf, input int hv);
    logic [3:0] r;
    r = v;
    if (d) r[hv] = 1'b0;
    if (a) r[lf] = 1'b1;
    return r;
  endfunction

  always @(negedge clk) begin : compare
    int cnt;
    bit rr;
    bit lr;
    cnt = $countones(q_valid);
    e_lf = lowest_zero(q_valid);
    e_hv = highest_one(q_valid);
    rr = !rst && !m_flush && (cnt < 4);
    lr = !rst && !m_flush && (cnt > 0);
    e_alloc = req_valid && rr;
    e_dealloc = !rst && (m_flush ? (cnt > 0) : (rel_valid && lr));
    chk("req_ready", req_ready, rr);
    chk("rel_ready", rel_ready, lr);
    chk("alloc", alloc, e_alloc);
    chk("dealloc", dealloc, e_dealloc);
    chk("flush_busy", flush_busy, !rst && m_flush);
    chk("alloc_idx", alloc_idx, e_lf);
    chk("rel_idx", rel_idx, e_hv);
    chk("count", count, cnt);
    chk("full", full, cnt == 4);
    chk("empty", empty, cnt == 0);
    chk("err", err, m_err);
    if (e_dealloc && !m_flush && m_known[e_hv]) chk("rel_data", rel_data, m_pay[e_hv]);
  end

  // Advance one clock: the bench plays the allocator and updates the model.
  task automatic tick();
    logic [3:0] nq;
    @(posedge clk);
    #1;
    if (rst) begin
      m_flush = 1'b0;
      m_err   = 1'b0;
      m_pred  = 4'b0000;
      nq      = 4'b0000;
    end else begin
      if (e_alloc) begin
        m_pay[e_lf]   = req_data;
        m_known[e_lf] = 1'b1;
      end
      if (q_valid != m_pred) m_err = 1'b1;
      nq = alloc_next(q_valid, e_alloc, e_dealloc, e_lf, e_hv);
      m_pred = nq;
      if (!m_flush && flush && (q_valid != 4'b0000)) m_flush = 1'b1;
      else if (m_flush && (q_valid == 4'b0000)) m_flush = 1'b0;
    end
    q_valid = force_en ? force_val : nq;
  endtask

  initial begin
    int nb;
    int nd;
    for (int i = 0; i < 4; i++) begin
      m_pay[i]   = 8'h00;
      m_known[i] = 1'b0;
    end
    rst = 1'b1; req_valid = 1'b0; req_data = 8'h00; rel_valid = 1'b0; flush = 1'b0;
    q_valid = 4'b0000; force_en = 1'b0; force_val = 4'b0000;
    #2 chk("lit_rst_req_ready", req_ready, 0);
    chk("lit_rst_flush_busy", flush_busy, 0);
    tick();
    tick();
    rst = 1'b0;
    #2 chk("lit_reset_empty", empty, 1);
    chk("lit_reset_err", err, 0);
    tick();

    // Fill all four slots with A0..A3
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_data  = 8'(160 + i);
      #2 chk("lit_fill_alloc_idx", alloc_idx, i);
      tick();
    end
    req_data = 8'hFF;
    #2 chk("lit_full_req_ready", req_ready, 0);
    chk("lit_full", full, 1);
    chk("lit_full_count", count, 4);
    tick();
    req_valid = 1'b0;

    // Two releases from full
    rel_valid = 1'b1;
    #2 chk("lit_rel0_idx", rel_idx, 3);
    chk("lit_rel0_data", rel_data, 8'hA3);
    tick();
    #2 chk("lit_rel1_idx", rel_idx, 2);
    chk("lit_rel1_data", rel_data, 8'hA2);
    tick();
    rel_valid = 1'b0;
    #2 chk("lit_count_after_rel", count, 2);
    tick();
    rel_valid = 1'b1;
    tick();

    // Simultaneous request and release at q_valid = 0001
    req_valid = 1'b1;
    req_data  = 8'h5A;
    #2 chk("lit_sim_alloc", alloc, 1);
    chk("lit_sim_dealloc", dealloc, 1);
    chk("lit_sim_alloc_idx", alloc_idx, 1);
    chk("lit_sim_rel_data", rel_data, 8'hA0);
    tick();
    req_valid = 1'b0;
    #2 chk("lit_sim_rel_idx", rel_idx, 1);
    chk("lit_sim_payload", rel_data, 8'h5A);
    tick();
    rel_valid = 1'b0;

    // Fill three slots, then flush with requests pending
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_data  = 8'(16 + i);
      tick();
    end
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    nb = 0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      req_valid = (i < 4);
      #2 if (flush_busy) nb++;
      if (dealloc) nd++;
      tick();
    end
    req_valid = 1'b0;
    chk("lit_flush_busy_cycles", nb, 4);
    chk("lit_flush_dealloc_cycles", nd, 3);

    // Flush while empty is ignored
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #2 chk("lit_empty_flush_busy", flush_busy, 0);
    chk("lit_empty_flush_dealloc", dealloc, 0);
    tick();

    // Reset in the middle of a flush
    req_valid = 1'b1;
    tick();
    tick();
    req_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #2 chk("lit_flush_started", flush_busy, 1);
    tick();
    rst = 1'b1;
    #2 chk("lit_rst_in_flush_busy", flush_busy, 0);
    chk("lit_rst_in_flush_dealloc", dealloc, 0);
    tick();
    rst = 1'b0;
    #2 chk("lit_post_rst_busy", flush_busy, 0);
    chk("lit_post_rst_count", count, 0);
    chk("lit_post_rst_err", err, 0);
    tick();

    // q_valid changes without any strobe: sticky error
    force_en = 1'b1;
    force_val = 4'b0100;
    tick();
    force_en = 1'b0;
    #2 chk("lit_err_not_yet", err, 0);
    tick();
    #2 chk("lit_err_set", err, 1);
    req_valid = 1'b1;
    rel_valid = 1'b1;
    req_data  = 8'h77;
    for (int i = 0; i < 3; i++) tick();
    req_valid = 1'b0;
    rel_valid = 1'b0;
    #2 chk("lit_err_sticky", err, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2 chk("lit_err_cleared", err, 0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
